if_stage: RTL and testbench
===========================

# if_stage

Instruction-fetch stage of the five-stage MIPS pipeline, directly upstream of the decode stage. It owns the architectural PC and drives the instruction SRAM request, selecting the next PC on each clock edge. It applies branch redirects from decode and hands `{ce, pc}` to decode through `if_to_id_bus`. A one-entry redirect-pending register makes sure a branch resolved while fetch is stalled is never lost.

## Interface
Parameters:
- `RESET_PC`, default `32'hBFC0_0000`: address of the first fetched instruction.
- `IF_TO_ID_WD`, default 33: width of `if_to_id_bus`.
- `BR_WD`, default 33: width of `br_bus`.

Ports:
- `clk` in 1: pipeline clock. All state updates on the rising edge.
- `rst` in 1: reset, asynchronous and active-low.
- `stall` in `StallBus` (6): `stall[0]==Stop` freezes PC update.
- `br_bus` in 33: `{br_e, br_addr[31:0]}` from decode.
- `if_to_id_bus` out 33: `{ce, pc[31:0]}` to decode.
- `inst_sram_en` out 1: fetch request.
- `inst_sram_wen` out 4: constant `4'b0`.
- `inst_sram_addr` out 32: fetch address.
- `inst_sram_wdata` out 32: constant `32'b0`.
- `fetch_adel` out 1: current PC is misaligned.

## Operation
**State.**
- `pc_reg[31:0]`
- `ce_reg`
- `pend_valid`, `pend_addr[31:0]`
- 2-state FSM:
  - `BOOT`: entered on reset. Stays in `BOOT` while `stall[0]==Stop`. Moves to `RUN` on the first edge with `stall[0]==NoStop`.
  - `RUN`: stays in `RUN` until reset.

**Reset values** (all set asynchronously while `rst==0`):
- `pc_reg = RESET_PC - 4`
- `ce_reg = 0`
- `pend_valid = 0`
- `pend_addr = 0`
- FSM in `BOOT`

**Outputs during reset:**
- `inst_sram_en = 0`
- `inst_sram_addr = RESET_PC - 4`
- `if_to_id_bus = {1'b0, RESET_PC-4}`
- `fetch_adel = 0`

**Next-PC priority** (`next_pc`, evaluated every cycle):
1. In `BOOT`: `RESET_PC`. Any `br_e` seen in `BOOT` is ignored.
2. Otherwise, if `br_e==1`: `br_addr`.
3. Otherwise, if `pend_valid==1`: `pend_addr`.
4. Otherwise: `pc_reg + 4`, modulo 2^32; `32'hFFFF_FFFC` wraps to 0.

**Update when `stall[0]==NoStop`:**
- `pc_reg <= next_pc`
- `ce_reg <= 1`
- `pend_valid <= 0`

**Update when `stall[0]==Stop`:**
- `pc_reg` and `ce_reg` hold.
- If `br_e==1`: `pend_valid <= 1` and `pend_addr <= br_addr`. A newer branch overwrites an older pending one.

**Simultaneous events.** When `br_e==1` and `pend_valid==1` on a non-stalled edge, the live `br_addr` wins and the pending entry is cleared.

**Combinational outputs.**
- `if_to_id_bus = {ce_reg, pc_reg}`
- `inst_sram_addr = pc_reg`
- `fetch_adel = ce_reg & (pc_reg[1:0] != 2'b00)`
- `inst_sram_en = ce_reg & ~fetch_adel`: a misaligned PC produces no SRAM access but still travels to decode.

## Timing
- Redirect latency: `br_e` sampled high at edge n (no stall) gives `inst_sram_addr == br_addr` during cycle n+1. The SRAM data for that fetch is presented to decode in cycle n+2.
- Stall latency: `stall[0]` is sampled on the edge. A stall asserted for k cycles holds `pc_reg` for exactly k edges.
- A pending redirect is consumed on the first non-stalled edge after it was captured.
- Boot:
  - First non-stalled edge after `rst` rises: `pc_reg = RESET_PC`, `ce_reg = 1`.
  - `inst_sram_en` rises in the following cycle.
- Reset asserted mid-operation: all state, including a pending redirect, is discarded immediately, without waiting for a clock edge.

## Configuration
`IF_BR_PENDING_EN`:
- **Defined:** the pending register and its rules are built as described above.
- **Undefined:**
  - `pend_valid`/`pend_addr` are not synthesised.
  - `br_bus` is sampled only on non-stalled edges; a `br_e` pulse present only during stalled cycles has no effect.
  - Decode must then hold `br_bus` stable until the stall clears.

## Test plan
- **Reset boot:** hold `rst=0` for 3 cycles, release with `stall=0` → `inst_sram_en` 0 until the first edge, then addresses `BFC0_0000`, `BFC0_0004`, `BFC0_0008` on consecutive cycles. `ce` is 0 before the first edge.
- **Branch redirect:** at PC `BFC0_0010`, drive `br_bus={1,BFC0_0100}` for one cycle, no stall → next address `BFC0_0100`, then `BFC0_0104`.
- **Branch during stall** (`IF_BR_PENDING_EN` defined): `stall[0]=Stop` for 3 cycles, `br_e` pulsed in the second with `BFC0_0200` → PC held, then `BFC0_0200` on the first free edge. With the macro undefined, PC continues `+4`.
- **Overwrite and priority:** two `br_e` pulses during one stall (`…300`, then `…400`) → fetch `…400`. Pending `…500` plus live `br_e` `…600` on a free edge → `…600`, and the pending entry is cleared.
- **Misaligned and wrap:** `br_addr=BFC0_0102` → `fetch_adel=1`, `inst_sram_en=0`, `if_to_id_bus={1,BFC0_0102}`. Branch to `FFFF_FFFC` → next PC `0000_0000`.
- **Async reset mid-run:** drop `rst` between clock edges while a redirect is pending → outputs reach reset values before the next edge. After release, fetch restarts at `BFC0_0000`.

Source files
------------

// File: rtl/if_stage.sv
// if_stage: MIPS instruction-fetch stage owning the PC and driving the instruction SRAM request.
// Optional IF_BR_PENDING_EN builds a one-entry register that holds a branch redirect taken during a stall.
`default_nettype none

module if_stage #(
   parameter logic [31:0] RESET_PC    = 32'hBFC0_0000,
   parameter int          IF_TO_ID_WD = 33,
   parameter int          BR_WD       = 33
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [5:0]             stall,
   input  logic [BR_WD-1:0]       br_bus,
   output logic [IF_TO_ID_WD-1:0] if_to_id_bus,
   output logic                   inst_sram_en,
   output logic [3:0]             inst_sram_wen,
   output logic [31:0]            inst_sram_addr,
   output logic [31:0]            inst_sram_wdata,
   output logic                   fetch_adel
);

   localparam logic STOP = 1'b1;

   typedef enum logic {
      BOOT = 1'b0,
      RUN  = 1'b1
   } state_e;

   state_e      state_q;
   logic [31:0] pc_q;
   logic [31:0] pc_d;
   logic        ce_q;
   logic        br_e;
   logic [31:0] br_addr;
   logic        stop;
   logic        unused_stall;

   assign br_e         = br_bus[32];
   assign br_addr      = br_bus[31:0];
   assign stop         = (stall[0] == STOP);
   assign unused_stall = ^stall[5:1];

`ifdef IF_BR_PENDING_EN
   logic        pend_valid_q;
   logic [31:0] pend_addr_q;
`endif

   // A live branch outranks a pending one; BOOT always forces RESET_PC.
   always_comb begin
      pc_d = pc_q + 32'd4;
      if (state_q == BOOT) begin
         pc_d = RESET_PC;
      end else if (br_e) begin
         pc_d = br_addr;
`ifdef IF_BR_PENDING_EN
      end else if (pend_valid_q) begin
         pc_d = pend_addr_q;
`endif
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= BOOT;
         pc_q         <= RESET_PC - 32'd4;
         ce_q         <= 1'b0;
`ifdef IF_BR_PENDING_EN
         pend_valid_q <= 1'b0;
         pend_addr_q  <= 32'd0;
`endif
      end else if (stop) begin
`ifdef IF_BR_PENDING_EN
         if (br_e) begin
            pend_valid_q <= 1'b1;
            pend_addr_q  <= br_addr;
         end
`endif
      end else begin
         state_q      <= RUN;
         pc_q         <= pc_d;
         ce_q         <= 1'b1;
`ifdef IF_BR_PENDING_EN
         pend_valid_q <= 1'b0;
`endif
      end
   end

   assign fetch_adel      = ce_q & (pc_q[1:0] != 2'b00);
   assign inst_sram_en    = ce_q & ~fetch_adel;
   assign inst_sram_addr  = pc_q;
   assign inst_sram_wen   = 4'b0000;
   assign inst_sram_wdata = 32'h0000_0000;
   assign if_to_id_bus    = {ce_q, pc_q};

endmodule

`default_nettype wire

// File: tb/tb_if_stage.sv
// tb_if_stage: directed-vector bench for if_stage; expectations are hand-computed constants.
`default_nettype none

module tb_if_stage;

   logic        clk;
   logic        rst;
   logic [5:0]  stall;
   logic [32:0] br_bus;
   logic [32:0] if_to_id_bus;
   logic        inst_sram_en;
   logic [3:0]  inst_sram_wen;
   logic [31:0] inst_sram_addr;
   logic [31:0] inst_sram_wdata;
   logic        fetch_adel;

   int vectors = 0;
   int errors  = 0;

   if_stage dut (
      .clk             (clk),
      .rst             (rst),
      .stall           (stall),
      .br_bus          (br_bus),
      .if_to_id_bus    (if_to_id_bus),
      .inst_sram_en    (inst_sram_en),
      .inst_sram_wen   (inst_sram_wen),
      .inst_sram_addr  (inst_sram_addr),
      .inst_sram_wdata (inst_sram_wdata),
      .fetch_adel      (fetch_adel)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [32:0] obs, input logic [32:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Aligned fetch in progress: address, bus with ce=1, enable high, no fault.
   task automatic chk_fetch(input string tag, input logic [31:0] addr);
      chk({tag, ".addr"}, {1'b0, inst_sram_addr}, {1'b0, addr});
      chk({tag, ".bus"}, if_to_id_bus, {1'b1, addr});
      chk({tag, ".en"}, {32'd0, inst_sram_en}, 33'd1);
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, ".addr"}, {1'b0, inst_sram_addr}, {1'b0, 32'hBFBF_FFFC});
      chk({tag, ".bus"}, if_to_id_bus, {1'b0, 32'hBFBF_FFFC});
      chk({tag, ".en"}, {32'd0, inst_sram_en}, 33'd0);
      chk({tag, ".adel"}, {32'd0, fetch_adel}, 33'd0);
   endtask

   initial begin
      rst    = 1'b0;
      stall  = 6'd0;
      br_bus = 33'd0;

      // Reset boot
      repeat (3) step();
      chk_reset("rst_hold");
      chk("const_wen", {29'd0, inst_sram_wen}, 33'd0);
      chk("const_wdata", {1'b0, inst_sram_wdata}, 33'd0);
      rst = 1'b1;
      #2;
      chk("boot_pre_ce", {32'd0, if_to_id_bus[32]}, 33'd0);
      chk("boot_pre_en", {32'd0, inst_sram_en}, 33'd0);
      step();
      chk_fetch("boot0", 32'hBFC0_0000);
      step();
      chk_fetch("boot1", 32'hBFC0_0004);
      step();
      chk_fetch("boot2", 32'hBFC0_0008);
      step();
      step();
      chk_fetch("seq10", 32'hBFC0_0010);

      // Branch redirect
      br_bus = {1'b1, 32'hBFC0_0100};
      step();
      br_bus = 33'd0;
      chk_fetch("br100", 32'hBFC0_0100);
      step();
      chk_fetch("br104", 32'hBFC0_0104);

      // Branch pulse in the middle of a 3-cycle stall
      stall = 6'b000001;
      step();
      chk_fetch("stall1", 32'hBFC0_0104);
      br_bus = {1'b1, 32'hBFC0_0200};
      step();
      br_bus = 33'd0;
      chk_fetch("stall2", 32'hBFC0_0104);
      step();
      chk_fetch("stall3", 32'hBFC0_0104);
      stall = 6'd0;
      step();
`ifdef IF_BR_PENDING_EN
      chk_fetch("stall_pend", 32'hBFC0_0200);

      // Newer pending branch overwrites the older one
      stall = 6'b000001;
      br_bus = {1'b1, 32'hBFC0_0300};
      step();
      br_bus = {1'b1, 32'hBFC0_0400};
      step();
      br_bus = 33'd0;
      chk_fetch("ovw_hold", 32'hBFC0_0200);
      stall = 6'd0;
      step();
      chk_fetch("ovw400", 32'hBFC0_0400);

      // Live branch beats a pending one, pending is then dropped
      stall = 6'b000001;
      br_bus = {1'b1, 32'hBFC0_0500};
      step();
      stall = 6'd0;
      br_bus = {1'b1, 32'hBFC0_0600};
      step();
      br_bus = 33'd0;
      chk_fetch("prio600", 32'hBFC0_0600);
      step();
      chk_fetch("prio604", 32'hBFC0_0604);
`else
      chk_fetch("stall_nopend", 32'hBFC0_0108);

      // Branch held stable through a stall is taken on the free edge
      stall = 6'b000001;
      br_bus = {1'b1, 32'hBFC0_0300};
      step();
      step();
      chk_fetch("held_hold", 32'hBFC0_0108);
      stall = 6'd0;
      step();
      br_bus = 33'd0;
      chk_fetch("held300", 32'hBFC0_0300);
      step();
      chk_fetch("held304", 32'hBFC0_0304);
      br_bus = {1'b1, 32'hBFC0_0600};
      step();
      br_bus = 33'd0;
      chk_fetch("br600", 32'hBFC0_0600);
      step();
      chk_fetch("seq604", 32'hBFC0_0604);
`endif

      // Misaligned fetch
      br_bus = {1'b1, 32'hBFC0_0102};
      step();
      br_bus = 33'd0;
      chk("mis_adel", {32'd0, fetch_adel}, 33'd1);
      chk("mis_en", {32'd0, inst_sram_en}, 33'd0);
      chk("mis_bus", if_to_id_bus, {1'b1, 32'hBFC0_0102});
      step();
      chk("mis2_bus", if_to_id_bus, {1'b1, 32'hBFC0_0106});
      chk("mis2_adel", {32'd0, fetch_adel}, 33'd1);

      // Wrap at the top of the address space
      br_bus = {1'b1, 32'hFFFF_FFFC};
      step();
      br_bus = 33'd0;
      chk_fetch("wrap_top", 32'hFFFF_FFFC);
      step();
      chk_fetch("wrap_zero", 32'h0000_0000);
      chk("wrap_adel", {32'd0, fetch_adel}, 33'd0);

      // Asynchronous reset between edges with a redirect pending
      stall = 6'b000001;
      br_bus = {1'b1, 32'hBFC0_0700};
      step();
      br_bus = 33'd0;
      #2;
      rst = 1'b0;
      #1;
      chk_reset("async_rst");
      stall = 6'd0;
      step();
      chk_reset("async_hold");
      rst = 1'b1;
      step();
      chk_fetch("reboot0", 32'hBFC0_0000);
      step();
      chk_fetch("reboot1", 32'hBFC0_0004);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule

`default_nettype wire
